onchip_mem_arbiter: RTL and testbench

ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

---
 rtl/onchip_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_arbiter.sv
// rtl/onchip_mem_arbiter.sv - round-robin arbiter sharing one single-port on-chip RAM between two requesters
module onchip_mem_arbiter #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_waitrequest,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_waitrequest,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                grant_id
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE
    } state_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_q, last_d;
    logic                is_write_q, is_write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic req0, req1, winner;

    assign req0   = m0_read | m0_write;
    assign req1   = m1_read | m1_write;
    // On a tie the requester not served last wins; a lone requester always wins.
    assign winner = (req0 && req1) ? ~last_q : req1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_d         = last_q;
        is_write_d     = is_write_q;
        addr_d         = addr_q;
        be_d           = be_q;
        wdata_d        = wdata_q;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        m0_readdata    = '0;
        m1_readdata    = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    grant_d = winner;
                    last_d  = winner;
                    state_d = ST_ISSUE;
                    // Read+write together is a write.
                    if (winner) begin
                        addr_d     = m1_address;
                        be_d       = m1_byteenable;
                        wdata_d    = m1_writedata;
                        is_write_d = m1_write;
                    end else begin
                        addr_d     = m0_address;
                        be_d       = m0_byteenable;
                        wdata_d    = m0_writedata;
                        is_write_d = m0_write;
                    end
                end
            end
            ST_ISSUE: begin
                mem_chipselect = 1'b1;
                mem_write      = is_write_q;
                if (is_write_q) begin
                    if (grant_q) m1_waitrequest = 1'b0;
                    else         m0_waitrequest = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (grant_q) begin
                    m1_waitrequest = 1'b0;
                    m1_readdata    = mem_readdata;
                end else begin
                    m0_waitrequest = 1'b0;
                    m0_readdata    = mem_readdata;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_address    = addr_q;
    assign mem_byteenable = be_q;
    assign mem_writedata  = wdata_q;
    assign mem_clken      = 1'b1;
    assign grant_id       = grant_q;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb/tb_onchip_mem_arbiter.sv - scoreboard bench for onchip_mem_arbiter
module tb_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  m0_address = '0, m1_address = '0;
    logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_writedata = '0, m1_writedata = '0;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [1:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_readdata = '0;
    logic        grant_id;

    onchip_mem_arbiter #(.ADDR_W(2), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_readdata(m0_readdata),
        .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_readdata(m1_readdata),
        .m1_waitrequest(m1_waitrequest),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM with one-cycle read latency.
    logic [31:0] mem [0:3] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write)
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            mem_readdata <= mem[mem_address];
        end
    end

    typedef struct {
        int          port;
        bit          is_read;
        logic [31:0] rdata;
        int          lat;
    } ack_t;

    typedef struct {
        logic [1:0]  addr;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        gid;
    } cmd_t;

    ack_t ack_q[$];
    cmd_t cmd_q[$];
    int   start_cyc [2];
    int   checks = 0;
    int   errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic void push_ack(input int port, input bit rd, input logic [31:0] rdata, input int lat);
        ack_t e;
        e.port = port; e.is_read = rd; e.rdata = rdata; e.lat = lat;
        ack_q.push_back(e);
    endfunction

    function automatic void push_cmd(input logic [1:0] a, input logic wr, input logic [3:0] be,
                                     input logic [31:0] wd, input logic gid);
        cmd_t c;
        c.addr = a; c.wr = wr; c.be = be; c.wdata = wd; c.gid = gid;
        cmd_q.push_back(c);
    endfunction

    // Monitor: every acknowledge and every memory strobe is matched against the queues.
    always @(negedge clk) begin : monitor
        ack_t        e;
        cmd_t        c;
        int          p;
        logic [31:0] rd;
        if (reset_n) begin
            chk("ack_exclusive", 32'(!m0_waitrequest && !m1_waitrequest), 32'h0);
            chk("mem_clken", 32'(mem_clken), 32'h1);
            if (m0_waitrequest) chk("m0_readdata_idle", m0_readdata, 32'h0);
            if (m1_waitrequest) chk("m1_readdata_idle", m1_readdata, 32'h0);
            if (!mem_chipselect) chk("mem_write_idle", 32'(mem_write), 32'h0);
            if (!m0_waitrequest || !m1_waitrequest) begin
                p  = m0_waitrequest ? 1 : 0;
                rd = (p == 1) ? m1_readdata : m0_readdata;
                if (ack_q.size() == 0) begin
                    chk("unexpected_ack_port", 32'(p), 32'hFFFF_FFFF);
                end else begin
                    e = ack_q.pop_front();
                    chk("ack_port", 32'(p), 32'(e.port));
                    chk("ack_grant_id", 32'(grant_id), 32'(e.port));
                    chk(e.is_read ? "ack_readdata" : "ack_readdata_wr", rd, e.rdata);
                    if (e.lat >= 0) chk("ack_latency", 32'(cyc - start_cyc[p]), 32'(e.lat));
                end
            end
            if (mem_chipselect) begin
                if (cmd_q.size() == 0) begin
                    chk("unexpected_mem_cmd_addr", 32'(mem_address), 32'hFFFF_FFFF);
                end else begin
                    c = cmd_q.pop_front();
                    chk("mem_address", 32'(mem_address), 32'(c.addr));
                    chk("mem_write", 32'(mem_write), 32'(c.wr));
                    chk("mem_byteenable", 32'(mem_byteenable), 32'(c.be));
                    chk("mem_grant_id", 32'(grant_id), 32'(c.gid));
                    if (c.wr) chk("mem_writedata", mem_writedata, c.wdata);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the acknowledge with the command dropped.
    task automatic drive(input int k, input logic rd, input logic wr, input logic [1:0] a,
                         input logic [3:0] be, input logic [31:0] wd, input bit scramble);
        bit got = 1'b0;
        if (k == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = wd;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = wd;
        end
        start_cyc[k] = cyc;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (!((k == 0) ? m0_waitrequest : m1_waitrequest)) got = 1'b1;
            else if (scramble && n == 1) begin
                if (k == 0) begin m0_address = ~a; m0_writedata = ~wd; m0_byteenable = ~be; end
                else        begin m1_address = ~a; m1_writedata = ~wd; m1_byteenable = ~be; end
            end
        end
        if (!got) chk("ack_timeout", 32'(k), 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        if (k == 0) begin m0_read = 1'b0; m0_write = 1'b0; end
        else        begin m1_read = 1'b0; m1_write = 1'b0; end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m0_waitrequest", 32'(m0_waitrequest), 32'h1);
        chk("rst_m1_waitrequest", 32'(m1_waitrequest), 32'h1);
        chk("rst_mem_chipselect", 32'(mem_chipselect), 32'h0);
        chk("rst_mem_write", 32'(mem_write), 32'h0);
        chk("rst_mem_address", 32'(mem_address), 32'h0);
        chk("rst_mem_byteenable", 32'(mem_byteenable), 32'h0);
        chk("rst_mem_writedata", mem_writedata, 32'h0);
        chk("rst_grant_id", 32'(grant_id), 32'h0);
        chk("rst_m0_readdata", m0_readdata, 32'h0);
        chk("rst_mem_clken", 32'(mem_clken), 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Lone write, then read back from the other requester.
        push_cmd(2'd2, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0); push_ack(0, 1'b0, 32'h0, 1);
        drive(0, 1'b0, 1'b1, 2'd2, 4'hF, 32'hDEADBEEF, 1'b0);
        push_cmd(2'd2, 1'b0, 4'hF, 32'h0, 1'b1); push_ack(1, 1'b1, 32'hDEADBEEF, 2);
        drive(1, 1'b1, 1'b0, 2'd2, 4'hF, 32'h0, 1'b0);

        // Byte-lane merge.
        push_cmd(2'd3, 1'b1, 4'hF, 32'h11223344, 1'b1); push_ack(1, 1'b0, 32'h0, 1);
        drive(1, 1'b0, 1'b1, 2'd3, 4'hF, 32'h11223344, 1'b0);
        push_cmd(2'd3, 1'b1, 4'h1, 32'h000000AA, 1'b0); push_ack(0, 1'b0, 32'h0, 1);
        drive(0, 1'b0, 1'b1, 2'd3, 4'h1, 32'h000000AA, 1'b0);
        push_cmd(2'd3, 1'b0, 4'hF, 32'h0, 1'b1); push_ack(1, 1'b1, 32'h112233AA, 2);
        drive(1, 1'b1, 1'b0, 2'd3, 4'hF, 32'h0, 1'b0);

        // Read and write together behaves as a write.
        push_cmd(2'd1, 1'b1, 4'hF, 32'hCAFEF00D, 1'b0); push_ack(0, 1'b0, 32'h0, 1);
        drive(0, 1'b1, 1'b1, 2'd1, 4'hF, 32'hCAFEF00D, 1'b0);
        push_cmd(2'd1, 1'b0, 4'hF, 32'h0, 1'b0); push_ack(0, 1'b1, 32'hCAFEF00D, 2);
        drive(0, 1'b1, 1'b0, 2'd1, 4'hF, 32'h0, 1'b0);

        // Fields changed after latching must not disturb the read in flight.
        push_cmd(2'd3, 1'b0, 4'hF, 32'h0, 1'b1); push_ack(1, 1'b1, 32'h112233AA, 2);
        drive(1, 1'b1, 1'b0, 2'd3, 4'hF, 32'h0, 1'b1);

        // Reset during the ISSUE cycle of a write aborts it.
        m0_write = 1'b1; m0_address = 2'd2; m0_byteenable = 4'hF; m0_writedata = 32'h55555555;
        @(posedge clk);
        #1;
        chk("abort_pre_chipselect", 32'(mem_chipselect), 32'h1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_chipselect", 32'(mem_chipselect), 32'h0);
        chk("abort_mem_write", 32'(mem_write), 32'h0);
        chk("abort_m0_waitrequest", 32'(m0_waitrequest), 32'h1);
        m0_write = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        push_cmd(2'd2, 1'b0, 4'hF, 32'h0, 1'b0); push_ack(0, 1'b1, 32'hDEADBEEF, 2);
        drive(0, 1'b1, 1'b0, 2'd2, 4'hF, 32'h0, 1'b0);

        // Both requesters writing back-to-back from reset alternate grants.
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            push_cmd(2'd0, 1'b1, 4'hF, 32'h0A000000 + 32'(i), 1'b0);
            push_ack(0, 1'b0, 32'h0, (i == 0) ? 1 : 3);
            push_cmd(2'd3, 1'b1, 4'hF, 32'h0B000000 + 32'(i), 1'b1);
            push_ack(1, 1'b0, 32'h0, 3);
        end
        fork
            for (int i = 0; i < 4; i++) drive(0, 1'b0, 1'b1, 2'd0, 4'hF, 32'h0A000000 + 32'(i), 1'b0);
            for (int j = 0; j < 4; j++) drive(1, 1'b0, 1'b1, 2'd3, 4'hF, 32'h0B000000 + 32'(j), 1'b0);
        join

        for (int i = 0; i < 20 && (ack_q.size() != 0 || cmd_q.size() != 0); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("ack_queue_drained", 32'(ack_q.size()), 32'h0);
        chk("cmd_queue_drained", 32'(cmd_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
